// File: rtl/phy_rx_deframer_if.sv
// Symbol/event bundle for the receive-side PHY lane deframer.
// The optional statistics counters appear only when PHY_RX_STATS_EN is defined.
interface phy_rx_deframer_if;
  logic [7:0]  data_in;
  logic [7:0]  control_in;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        pkt_start;
  logic        pkt_is_sdp;
  logic        pkt_end;
  logic        pkt_abort;
  logic [10:0] pkt_len;
  logic        os_valid;
  logic [1:0]  os_type;
  logic        error;
`ifdef PHY_RX_STATS_EN
  logic [15:0] good_pkt_cnt;
  logic [15:0] err_cnt;

  modport master (
    output data_in, control_in,
    input  data_out, data_valid, pkt_start, pkt_is_sdp, pkt_end, pkt_abort,
           pkt_len, os_valid, os_type, error, good_pkt_cnt, err_cnt
  );
  modport slave (
    input  data_in, control_in,
    output data_out, data_valid, pkt_start, pkt_is_sdp, pkt_end, pkt_abort,
           pkt_len, os_valid, os_type, error, good_pkt_cnt, err_cnt
  );
`else
  modport master (
    output data_in, control_in,
    input  data_out, data_valid, pkt_start, pkt_is_sdp, pkt_end, pkt_abort,
           pkt_len, os_valid, os_type, error
  );
  modport slave (
    input  data_in, control_in,
    output data_out, data_valid, pkt_start, pkt_is_sdp, pkt_end, pkt_abort,
           pkt_len, os_valid, os_type, error
  );
`endif
endinterface

// File: rtl/phy_rx_deframer.sv
// Receive-side deframer for the 8-bit PHY lane: delivers STP/SDP..END/EDB
// packets as a qualified byte stream, reports COM-led ordered sets and flags
// framing violations. All outputs are registered (one cycle latency).
// Define PHY_RX_STATS_EN to add saturating good-packet and error counters.
//
// state   | meaning
// IDLE    | between frames, expecting STP/SDP or COM
// PKT     | inside a packet, collecting payload bytes
// OS_COM  | COM seen, waiting for the ordered-set character
// OS_BODY | ordered-set characters being counted (saturates at 3)
module phy_rx_deframer #(
  parameter int MAX_LEN = 2047
) (
  input  logic            clk,
  input  logic            reset_l,
  phy_rx_deframer_if.slave rx
);
  typedef enum logic [1:0] {IDLE, PKT, OS_COM, OS_BODY} state_t;

  localparam logic [7:0]  SYM_STP = 8'hfb;
  localparam logic [7:0]  SYM_SDP = 8'h5c;
  localparam logic [7:0]  SYM_END = 8'hfd;
  localparam logic [7:0]  SYM_EDB = 8'hfe;
  localparam logic [7:0]  SYM_SKP = 8'h1c;
  localparam logic [7:0]  SYM_IDL = 8'h7c;
  localparam logic [7:0]  SYM_FTS = 8'h3c;
  localparam logic [7:0]  SYM_COM = 8'hbc;
  localparam logic [10:0] LEN_MAX = 11'(MAX_LEN);

  state_t      state, state_nx;
  logic [10:0] len_cnt, len_nx;
  logic [1:0]  os_cnt, os_cnt_nx;
  logic [1:0]  os_cur, os_cur_nx;

  logic [7:0]  data_out_q, data_out_nx;
  logic        dv_nx, start_nx, end_nx, abort_nx, osv_nx, err_nx;
  logic        sdp_q, sdp_nx;
  logic [10:0] pkt_len_q, pkt_len_nx;
  logic [1:0]  os_type_q, os_type_nx;
  logic        dv_q, start_q, end_q, abort_q, osv_q, err_q;

  logic        k;
  logic [1:0]  sym_os;
  logic        do_idle;
  logic        unused_ctrl;

  assign k           = rx.control_in[0];
  assign unused_ctrl = ^rx.control_in[7:1];

  // Ordered-set character class of the current symbol (00 = not an OS char).
  always_comb begin
    sym_os = 2'b00;
    if (k) begin
      case (rx.data_in)
        SYM_SKP: sym_os = 2'b01;
        SYM_IDL: sym_os = 2'b10;
        SYM_FTS: sym_os = 2'b11;
        default: sym_os = 2'b00;
      endcase
    end
  end

  // Next-state and registered-output values for the symbol on the lane.
  always_comb begin
    state_nx    = state;
    len_nx      = len_cnt;
    os_cnt_nx   = os_cnt;
    os_cur_nx   = os_cur;
    data_out_nx = data_out_q;
    sdp_nx      = sdp_q;
    pkt_len_nx  = pkt_len_q;
    os_type_nx  = os_type_q;
    dv_nx       = 1'b0;
    start_nx    = 1'b0;
    end_nx      = 1'b0;
    abort_nx    = 1'b0;
    osv_nx      = 1'b0;
    err_nx      = 1'b0;
    do_idle     = 1'b0;

    case (state)
      IDLE: do_idle = 1'b1;
      PKT: begin
        if (!k) begin
          dv_nx       = 1'b1;
          data_out_nx = rx.data_in;
          if (len_cnt != LEN_MAX) len_nx = len_cnt + 11'd1;
        end else if (rx.data_in == SYM_END) begin
          end_nx     = 1'b1;
          pkt_len_nx = len_cnt;
          state_nx   = IDLE;
        end else if (rx.data_in == SYM_EDB) begin
          abort_nx   = 1'b1;
          pkt_len_nx = len_cnt;
          state_nx   = IDLE;
        end else if (rx.data_in == SYM_STP || rx.data_in == SYM_SDP) begin
          // Restart: old packet is aborted and the new one opens in the same cycle.
          err_nx     = 1'b1;
          abort_nx   = 1'b1;
          pkt_len_nx = len_cnt;
          start_nx   = 1'b1;
          sdp_nx     = (rx.data_in == SYM_SDP);
          len_nx     = '0;
        end else begin
          err_nx     = 1'b1;
          abort_nx   = 1'b1;
          pkt_len_nx = len_cnt;
          state_nx   = (rx.data_in == SYM_COM) ? OS_COM : IDLE;
        end
      end
      OS_COM: begin
        if (k && rx.data_in == SYM_COM) begin
          state_nx = OS_COM;
        end else if (sym_os != 2'b00) begin
          state_nx  = OS_BODY;
          os_cur_nx = sym_os;
          os_cnt_nx = 2'd1;
        end else begin
          err_nx  = 1'b1;
          do_idle = 1'b1;
        end
      end
      OS_BODY: begin
        if (sym_os != 2'b00 && sym_os == os_cur) begin
          if (os_cnt != 2'd3) os_cnt_nx = os_cnt + 2'd1;
          if (os_cnt == 2'd2) begin
            osv_nx     = 1'b1;
            os_type_nx = os_cur;
          end
        end else begin
          if (os_cnt != 2'd3) err_nx = 1'b1;
          do_idle = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase

    // Symbols handled as if the deframer were idle (also the fall-through path).
    if (do_idle) begin
      state_nx = IDLE;
      if (k && (rx.data_in == SYM_STP || rx.data_in == SYM_SDP)) begin
        state_nx = PKT;
        start_nx = 1'b1;
        sdp_nx   = (rx.data_in == SYM_SDP);
        len_nx   = '0;
      end else if (k && rx.data_in == SYM_COM) begin
        state_nx = OS_COM;
      end else begin
        err_nx = 1'b1;
      end
    end
  end

  // State register and internal counters.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state   <= IDLE;
      len_cnt <= '0;
      os_cnt  <= '0;
      os_cur  <= '0;
    end else begin
      state   <= state_nx;
      len_cnt <= len_nx;
      os_cnt  <= os_cnt_nx;
      os_cur  <= os_cur_nx;
    end
  end

  // Registered outputs; strobes are recomputed every cycle so they last one cycle.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      data_out_q <= '0;
      dv_q       <= 1'b0;
      start_q    <= 1'b0;
      end_q      <= 1'b0;
      abort_q    <= 1'b0;
      osv_q      <= 1'b0;
      err_q      <= 1'b0;
      sdp_q      <= 1'b0;
      pkt_len_q  <= '0;
      os_type_q  <= '0;
    end else begin
      data_out_q <= data_out_nx;
      dv_q       <= dv_nx;
      start_q    <= start_nx;
      end_q      <= end_nx;
      abort_q    <= abort_nx;
      osv_q      <= osv_nx;
      err_q      <= err_nx;
      sdp_q      <= sdp_nx;
      pkt_len_q  <= pkt_len_nx;
      os_type_q  <= os_type_nx;
    end
  end

  assign rx.data_out   = data_out_q;
  assign rx.data_valid = dv_q;
  assign rx.pkt_start  = start_q;
  assign rx.pkt_is_sdp = sdp_q;
  assign rx.pkt_end    = end_q;
  assign rx.pkt_abort  = abort_q;
  assign rx.pkt_len    = pkt_len_q;
  assign rx.os_valid   = osv_q;
  assign rx.os_type    = os_type_q;
  assign rx.error      = err_q;

`ifdef PHY_RX_STATS_EN
  logic [15:0] good_cnt_q, err_cnt_q;

  // Saturating statistics, updated on the same edge as the matching strobe.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      good_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      if (end_nx && good_cnt_q != 16'hffff) good_cnt_q <= good_cnt_q + 16'd1;
      if (err_nx && err_cnt_q != 16'hffff)  err_cnt_q  <= err_cnt_q + 16'd1;
    end
  end

  assign rx.good_pkt_cnt = good_cnt_q;
  assign rx.err_cnt      = err_cnt_q;
`endif
endmodule

// File: doc/phy_rx_deframer.md
# phy_rx_deframer

Receive-side deframer for the 8-bit PHY lane. It consumes the byte-plus-control-flag stream produced by the transmit-side symbol mux and classifies each symbol. Packets framed by STP/SDP ... END/EDB are delivered as a qualified data-byte stream with start, end and abort strobes. COM-led ordered sets (SKP/IDL/FTS) are reported as single-cycle events, and framing violations are flagged.

## Interface
- MAX_LEN, 2047: packet length counter saturation value; `PKT_LEN` is 11 bits wide.
- CLK  input  1  lane clock; all state updates on the rising edge.
- RESET_L  input  1  reset, asynchronous and active-low.
- DATA_IN  input  8  lane symbol.
- CONTROL_IN  input  8  bit 0 = K flag (1 = control symbol, 0 = data byte); bits 7:1 ignored.
- DATA_OUT  output  8  registered packet data byte.
- DATA_VALID  output  1  `DATA_OUT` is a packet payload byte.
- PKT_START  output  1  pulse: STP or SDP accepted.
- PKT_IS_SDP  output  1  type of current/last packet (0 = STP, 1 = SDP); held until next start.
- PKT_END  output  1  pulse: END closed packet normally.
- PKT_ABORT  output  1  pulse: packet closed by EDB or by a violation.
- PKT_LEN  output  11  payload byte count, valid with `PKT_END`/`PKT_ABORT`; held otherwise.
- OS_VALID  output  1  pulse: complete ordered set received.
- OS_TYPE  output  2  01 = SKP, 10 = IDL, 11 = FTS; held until next `OS_VALID`.
- ERROR  output  1  pulse: framing violation.

## Operation
- Symbol codes:
  - STP = 8'hfb, SDP = 8'h5c, END = 8'hfd, EDB = 8'hfe (start/end characters).
  - SKP = 8'h1c, IDL = 8'h7c, FTS = 8'h3c (ordered-set characters).
  - COM = 8'hbc.
  - A code is only recognized with K = 1.
- States: IDLE, PKT, OS_COM, OS_BODY.
- IDLE:
  - K STP/SDP → PKT; `PKT_START`; set `PKT_IS_SDP`; clear length.
  - K COM → OS_COM.
  - K=0 data or any other K → `ERROR`, stay.
- PKT:
  - K=0 → `DATA_VALID`, `DATA_OUT`=byte, length+1 (saturates at MAX_LEN, no error).
  - K END → `PKT_END`, `PKT_LEN`=length, → IDLE. A zero-length packet is legal.
  - K EDB → `PKT_ABORT`, → IDLE, no `ERROR`.
  - K STP/SDP → `ERROR` + `PKT_ABORT` for the old packet and `PKT_START` for the new one, same cycle; stay PKT with length cleared.
  - K COM → `ERROR` + `PKT_ABORT`, → OS_COM.
  - Other K → `ERROR` + `PKT_ABORT`, → IDLE.
- OS_COM:
  - Repeated COM → stay.
  - K SKP/IDL/FTS → OS_BODY; latch type; count=1.
  - Anything else → `ERROR`, then that symbol is processed as in IDLE in the same cycle.
- OS_BODY:
  - Same symbol → count+1, saturating at 3. On reaching 3: `OS_VALID`, drive `OS_TYPE`.
  - Further identical symbols → absorbed silently.
  - Different symbol with count<3 → `ERROR`, then processed as in IDLE.
  - Different symbol with count≥3 → processed as in IDLE, no error.

## Timing
- All outputs are registered: the response to the symbol sampled at edge n appears after edge n and holds one cycle. Latency = 1 cycle.
- All strobes (`DATA_VALID`, `PKT_START`, `PKT_END`, `PKT_ABORT`, `OS_VALID`, `ERROR`) are single-cycle pulses, one per offending or qualifying symbol.
- Reset asserted: state=IDLE, every output 0 (including `DATA_OUT`, `PKT_LEN`, `OS_TYPE`, `PKT_IS_SDP`), counters 0. Effect is immediate and asynchronous.
- Reset during a packet or ordered set: the partial frame is discarded silently; no `PKT_ABORT`/`ERROR` after release.
- Deassertion: the first symbol is sampled at the first rising edge with RESET_L=1.
- No back-pressure; one symbol is accepted every cycle.

## Configuration
- PHY_RX_STATS_EN defined:
  - Adds outputs `GOOD_PKT_CNT[15:0]` (+1 per `PKT_END`) and `ERR_CNT[15:0]` (+1 per `ERROR`).
  - Both saturate at 16'hffff and reset to 0.
- Undefined: the ports and counters do not exist.
- Deframing behaviour is identical in both builds.

## Test plan
- STP, 8'h01, 8'h02, END (K=1,0,0,1) → `PKT_START` at cycle 1; `DATA_VALID` with 01 then 02; `PKT_END` with `PKT_LEN`=2, `PKT_IS_SDP`=0; `ERROR` never.
- SDP, four data bytes, EDB → `PKT_IS_SDP`=1, four `DATA_VALID`, `PKT_ABORT` with `PKT_LEN`=4, no `ERROR`, no `PKT_END`.
- COM×4, SKP×4, COM×4, IDL×4 → `OS_VALID` on the 3rd SKP (`OS_TYPE`=01) and on the 3rd IDL (`OS_TYPE`=10); no `ERROR`.
- Violations:
  - COM, SKP, IDL → `ERROR` on IDL, no `OS_VALID`.
  - STP, 8'haa, STP → `ERROR` + `PKT_ABORT` (`PKT_LEN`=1) + `PKT_START` in the same cycle.
  - Data byte 8'h55 in IDLE → `ERROR`, no `DATA_VALID`.
- RESET_L pulsed low mid-packet after STP + 3 bytes → all outputs 0 immediately. Subsequent END → `ERROR` only, no `PKT_END`.
- With PHY_RX_STATS_EN: three good packets + two violations → `GOOD_PKT_CNT`=3, `ERR_CNT`=2. Counters saturate at 16'hffff under forced long run.
